vga_frame_reader: RTL and testbench

Display-side reader for the camera frame buffer. The capture path writes 12-bit RGB444 pixels into a 640x480 BRAM. This block generates 640x480@60 VGA timing on a single 25 MHz pixel clock, reads that BRAM in raster order, and drives RGB444 plus syncs. Pixel data, syncs and data-enable leave the block mutually aligned, whatever the BRAM read latency.

---
 rtl/vga_frame_reader.sv | 149 ++++++++++++++
 tb/tb_vga_frame_reader.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_reader.sv
// VGA frame reader: raster timing generator and frame-buffer read path.
// Pixel data, syncs and data-enable leave the block mutually aligned.
module vga_frame_reader #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int RD_LAT   = 1,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_en,
    input  logic [11:0] i_pix_data,
    output logic [18:0] o_pix_addr,
    output logic        o_pix_rden,
    output logic [3:0]  o_red,
    output logic [3:0]  o_green,
    output logic [3:0]  o_blue,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_de,
    output logic        o_frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    // Counter-to-output latency: read stage, BRAM, output register.
    localparam int L = RD_LAT + 2;

    localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_AEND  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END  = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_AEND  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END  = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          frame_en;
    logic          act_q;

    logic          at_origin;
    logic          at_end;
    logic          active;
    logic          hs_on;
    logic          vs_on;
    logic          en_now;
    logic          vld;

    logic [L-1:0]  de_dl;
    logic [L-1:0]  hs_dl;
    logic [L-1:0]  vs_dl;
    logic [L-1:0]  fs_dl;
    logic [L-2:0]  vld_dl;
    logic [11:0]   rgb_q;

    assign at_origin = (h_cnt == '0) && (v_cnt == '0);
    assign at_end    = (h_cnt == H_LAST) && (v_cnt == V_LAST);
    assign active    = (h_cnt < H_AEND) && (v_cnt < V_AEND);
    assign hs_on     = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    assign vs_on     = (v_cnt >= VS_BEG) && (v_cnt < VS_END);

    // The enable seen at (0,0) must already govern the first pixel read.
    assign en_now    = at_origin ? i_en : frame_en;
    assign vld       = active && en_now;

    // Raster counters: h wraps every line, v advances on h wrap.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
        end else begin
            h_cnt <= h_cnt + HW'(1);
        end
    end

    // Frame enable is captured once per frame to avoid tearing.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            frame_en <= 1'b0;
        end else if (at_origin) begin
            frame_en <= i_en;
        end
    end

    // Read stage: address advances after each active pixel, no multiply.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            act_q      <= 1'b0;
            o_pix_rden <= 1'b0;
            o_pix_addr <= '0;
        end else begin
            act_q      <= active;
            o_pix_rden <= vld;
            if (at_end) begin
                o_pix_addr <= '0;
            end else if (act_q) begin
                o_pix_addr <= o_pix_addr + 19'd1;
            end
        end
    end

    // Timing flags ride a delay line matched to the data path.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            de_dl  <= '0;
            hs_dl  <= '0;
            vs_dl  <= '0;
            fs_dl  <= '0;
            vld_dl <= '0;
        end else begin
            de_dl  <= {de_dl[L-2:0], active};
            hs_dl  <= {hs_dl[L-2:0], hs_on};
            vs_dl  <= {vs_dl[L-2:0], vs_on};
            fs_dl  <= {fs_dl[L-2:0], at_origin};
            vld_dl <= {vld_dl[L-3:0], vld};
        end
    end

    // Output register: capture BRAM data only for enabled active pixels.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= vld_dl[L-2] ? i_pix_data : 12'h000;
        end
    end

    assign o_red         = rgb_q[11:8];
    assign o_green       = rgb_q[7:4];
    assign o_blue        = rgb_q[3:0];
    assign o_de          = de_dl[L-1];
    assign o_frame_start = fs_dl[L-1];
    assign o_hsync       = hs_dl[L-1] ? SYNC_POL : ~SYNC_POL;
    assign o_vsync       = vs_dl[L-1] ? SYNC_POL : ~SYNC_POL;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Bench for vga_frame_reader: two instances (RD_LAT 1 and 3) on a
// reduced raster, checked against a position-based reference model.
module tb_vga_frame_reader;

    localparam int HA = 40, HF = 4, HS = 6, HB = 5;
    localparam int VA = 30, VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b1;
    always #5 clk = ~clk;

    logic [18:0] a_addr, b_addr;
    logic        a_rden, b_rden;
    logic [3:0]  a_r, a_g, a_b, b_r, b_g, b_b;
    logic        a_hs, a_vs, a_de, a_fs;
    logic        b_hs, b_vs, b_de, b_fs;
    logic [11:0] a_data, b_data;
    logic [11:0] a_q;
    logic [11:0] b_q [3];

    vga_frame_reader #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .RD_LAT(1), .SYNC_POL(1'b0)
    ) dut_a (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_pix_data(a_data),
        .o_pix_addr(a_addr), .o_pix_rden(a_rden),
        .o_red(a_r), .o_green(a_g), .o_blue(a_b),
        .o_hsync(a_hs), .o_vsync(a_vs), .o_de(a_de),
        .o_frame_start(a_fs)
    );

    vga_frame_reader #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .RD_LAT(3), .SYNC_POL(1'b1)
    ) dut_b (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_pix_data(b_data),
        .o_pix_addr(b_addr), .o_pix_rden(b_rden),
        .o_red(b_r), .o_green(b_g), .o_blue(b_b),
        .o_hsync(b_hs), .o_vsync(b_vs), .o_de(b_de),
        .o_frame_start(b_fs)
    );

    // BRAM models: return addr[11:0] RD_LAT cycles later, junk when not read.
    always @(posedge clk) begin
        a_q    <= a_rden ? a_addr[11:0] : 12'hEEE;
        b_q[0] <= b_rden ? b_addr[11:0] : 12'hEEE;
        b_q[1] <= b_q[0];
        b_q[2] <= b_q[1];
    end
    assign a_data = a_q;
    assign b_data = b_q[2];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    bit mon = 1'b0;
    bit en_hist [64];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    // cyc = raster position the counters hold in the current cycle.
    always @(posedge clk) begin
        if (rst) begin
            cyc <= 0;
        end else begin
            if (cyc % FT == 0) en_hist[(cyc / FT) % 64] = en;
            cyc <= cyc + 1;
        end
    end

    function automatic void pos_info(input int p, output bit act,
                                     output bit hs, output bit vs,
                                     output bit fs, output int idx,
                                     output bit fen);
        int h, v;
        h   = p % HT;
        v   = (p / HT) % VT;
        act = (h < HA) && (v < VA);
        hs  = (h >= HA + HF) && (h < HA + HF + HS);
        vs  = (v >= VA + VF) && (v < VA + VF + VS);
        fs  = (p % FT) == 0;
        idx = v * HA + h;
        fen = en_hist[(p / FT) % 64];
    endfunction

    task automatic model_chk(input string t, input int lat, input bit pol,
                             input logic [18:0] addr, input logic rden,
                             input logic [11:0] rgb, input logic hs,
                             input logic vs, input logic de,
                             input logic fs);
        bit act, hsa, vsa, fsa, fen;
        int idx;
        logic [11:0] e_rgb;
        if (cyc >= lat) begin
            pos_info(cyc - lat, act, hsa, vsa, fsa, idx, fen);
            e_rgb = (act && fen) ? idx[11:0] : 12'h000;
        end else begin
            act = 0; hsa = 0; vsa = 0; fsa = 0; e_rgb = 12'h000;
        end
        chk({t, "_de"}, de, act);
        chk({t, "_hs"}, hs, hsa ? pol : !pol);
        chk({t, "_vs"}, vs, vsa ? pol : !pol);
        chk({t, "_fs"}, fs, fsa);
        chk({t, "_rgb"}, rgb, e_rgb);
        if (cyc >= 1) begin
            pos_info(cyc - 1, act, hsa, vsa, fsa, idx, fen);
            chk({t, "_rden"}, rden, act && fen);
            if (act && fen) chk({t, "_addr"}, addr, idx);
        end else begin
            chk({t, "_rden"}, rden, 1'b0);
            chk({t, "_addr"}, addr, 0);
        end
    endtask

    always @(negedge clk) begin
        if (mon) begin
            model_chk("A", 3, 1'b0, a_addr, a_rden, {a_r, a_g, a_b},
                      a_hs, a_vs, a_de, a_fs);
            model_chk("B", 5, 1'b1, b_addr, b_rden, {b_r, b_g, b_b},
                      b_hs, b_vs, b_de, b_fs);
        end
    end

    task automatic wait_cyc(input int target);
        int k;
        k = 0;
        while (cyc != target && k < 20000) begin
            @(negedge clk);
            k++;
        end
        chk("wait_cyc", cyc, target);
    endtask

    typedef struct {
        int          cyc;
        bit          de;
        bit          hs;
        bit          vs;
        bit          fs;
        logic [11:0] rgb;
        bit          rden;
        int          addr;
    } vec_t;

    vec_t tbl [17];

    initial begin
        int c_rden, c_de, c_nz;
        int rst_at;

        tbl[0]  = '{2,    0, 1, 1, 0, 12'h000, 1, 1};
        tbl[1]  = '{3,    1, 1, 1, 1, 12'h000, 1, 2};
        tbl[2]  = '{8,    1, 1, 1, 0, 12'h005, 1, 7};
        tbl[3]  = '{43,   0, 1, 1, 0, 12'h000, 0, 0};
        tbl[4]  = '{47,   0, 0, 1, 0, 12'h000, 0, 0};
        tbl[5]  = '{52,   0, 0, 1, 0, 12'h000, 0, 0};
        tbl[6]  = '{53,   0, 1, 1, 0, 12'h000, 0, 0};
        tbl[7]  = '{58,   1, 1, 1, 0, 12'h028, 1, 42};
        tbl[8]  = '{1635, 1, 1, 1, 0, 12'h4AD, 1, 1199};
        tbl[9]  = '{1637, 1, 1, 1, 0, 12'h4AF, 0, 0};
        tbl[10] = '{1762, 0, 1, 1, 0, 12'h000, 0, 0};
        tbl[11] = '{1763, 0, 1, 0, 0, 12'h000, 0, 0};
        tbl[12] = '{1872, 0, 1, 0, 0, 12'h000, 0, 0};
        tbl[13] = '{1873, 0, 1, 1, 0, 12'h000, 0, 0};
        tbl[14] = '{2035, 0, 1, 1, 0, 12'h000, 0, 0};
        tbl[15] = '{2036, 0, 1, 1, 0, 12'h000, 1, 0};
        tbl[16] = '{2038, 1, 1, 1, 1, 12'h000, 1, 2};

        rst = 1'b1;
        en  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mon = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_a_de", a_de, 1'b0);
        chk("rst_a_hs", a_hs, 1'b1);
        chk("rst_a_vs", a_vs, 1'b1);
        chk("rst_b_hs", b_hs, 1'b0);
        chk("rst_a_rgb", {a_r, a_g, a_b}, 0);
        chk("rst_a_addr", a_addr, 0);
        chk("rst_a_rden", a_rden, 1'b0);
        chk("rst_a_fs", a_fs, 1'b0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            wait_cyc(tbl[i].cyc);
            chk("tbl_de", a_de, tbl[i].de);
            chk("tbl_hs", a_hs, tbl[i].hs);
            chk("tbl_vs", a_vs, tbl[i].vs);
            chk("tbl_fs", a_fs, tbl[i].fs);
            chk("tbl_rgb", {a_r, a_g, a_b}, tbl[i].rgb);
            chk("tbl_rden", a_rden, tbl[i].rden);
            if (tbl[i].rden) chk("tbl_addr", a_addr, tbl[i].addr);
        end

        // Frame 2 starts disabled; enable rises mid-frame.
        en = 1'b0;
        wait_cyc(2 * FT + 1);
        c_rden = 0; c_de = 0; c_nz = 0;
        for (int i = 0; i < FT; i++) begin
            if (i == FT / 2) en = 1'b1;
            c_rden += a_rden + b_rden;
            c_de   += a_de;
            if ({a_r, a_g, a_b} != 0 || {b_r, b_g, b_b} != 0) c_nz++;
            @(negedge clk);
        end
        chk("gate_rden", c_rden, 0);
        chk("gate_de", c_de, HA * VA);
        chk("gate_rgb", c_nz, 0);
        c_rden = 0;
        for (int i = 0; i < FT; i++) begin
            c_rden += a_rden;
            @(negedge clk);
        end
        chk("full_rden", c_rden, HA * VA);

        // Reset at line 20 of a frame.
        wait_cyc(4 * FT + 20 * HT);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_a_de", a_de, 1'b0);
        chk("mid_a_hs", a_hs, 1'b1);
        chk("mid_a_vs", a_vs, 1'b1);
        chk("mid_b_vs", b_vs, 1'b0);
        chk("mid_a_rgb", {a_r, a_g, a_b}, 0);
        chk("mid_a_addr", a_addr, 0);
        chk("mid_a_rden", a_rden, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk("rel_a_fs", a_fs, k == 3);
            chk("rel_b_fs", b_fs, k == 5);
            if (k == 1) begin
                chk("rel_a_rden", a_rden, 1'b1);
                chk("rel_a_addr", a_addr, 0);
            end
        end

        // Random enable pattern with one random reset pulse.
        rst_at = $urandom_range(300, 3000);
        for (int i = 0; i < 2 * FT; i++) begin
            if (i % 200 == 0) en = 1'($urandom % 2);
            if (i == rst_at) rst = 1'b1;
            if (i == rst_at + 2) rst = 1'b0;
            @(negedge clk);
        end

        mon = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
